// File: rtl/exc_sched_if.sv
// exc_sched_if: signal bundle between the pipeline/CP0 and the exception scheduler.
//   master : pipeline side; drives memory-stage info, interrupt lines, CP0 status/EPC,
//            and receives the CP0 write controls, synced interrupts, flush/stall and redirect.
//   slave  : exc_sched side; the mirror image of master.
interface exc_sched_if;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_bd;
    logic        m_exc_valid;
    logic [4:0]  m_exc_code;
    logic [31:0] m_bva;
    logic        m_eret;
    logic [5:0]  hw_int;
    logic        status_ie;
    logic        status_exl;
    logic [7:0]  status_im;
    logic [1:0]  cause_ip_sw;
    logic [31:0] epc_in;
    logic        cp0_en;
    logic        cp0_exl;
    logic        cp0_bd;
    logic [4:0]  cp0_exc;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_bva;
    logic        cp0_exl_clr;
    logic [5:0]  hw_ip;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output m_valid, m_pc, m_bd, m_exc_valid, m_exc_code, m_bva, m_eret,
               hw_int, status_ie, status_exl, status_im, cause_ip_sw, epc_in,
        input  cp0_en, cp0_exl, cp0_bd, cp0_exc, cp0_epc, cp0_bva, cp0_exl_clr,
               hw_ip, flush, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  m_valid, m_pc, m_bd, m_exc_valid, m_exc_code, m_bva, m_eret,
               hw_int, status_ie, status_exl, status_im, cause_ip_sw, epc_in,
        output cp0_en, cp0_exl, cp0_bd, cp0_exc, cp0_epc, cp0_bva, cp0_exl_clr,
               hw_ip, flush, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_sched.sv
// exc_sched: accepts one interrupt/exception/ERET from the memory stage, commits it to CP0,
// flushes the pipeline for FLUSH_CYCLES cycles and then redirects fetch.
//   clk, rst : clock and synchronous active-high reset
//   bus      : exc_sched_if.slave carrying memory-stage inputs, CP0 status/EPC, interrupt
//              lines, and the CP0 write / flush / stall / redirect outputs
module exc_sched #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic        clk,
    input logic        rst,
    exc_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, REDIRECT} state_t;

    state_t      state, state_n;
    logic [5:0]  sync0, hw_ip;
    logic [3:0]  cnt;
    logic [4:0]  exc_l;
    logic [31:0] epc_l, bva_l, ret_l;
    logic        bd_l, eret_l;
    logic        int_pend, open, take_int, take_exc, take_eret, accept;

    assign int_pend  = bus.status_ie & ~bus.status_exl & |(bus.status_im & {hw_ip, bus.cause_ip_sw});
    assign open      = state == IDLE && !rst && bus.m_valid;
    assign take_int  = open & int_pend;
    assign take_exc  = open & ~int_pend & bus.m_exc_valid;
    assign take_eret = open & ~int_pend & ~bus.m_exc_valid & bus.m_eret;
    assign accept    = take_int | take_exc | take_eret;

    // CP0 data outputs come straight from the latches, which only change when an
    // interrupt/exception is accepted, so they hold their last written values otherwise.
    assign bus.cp0_exc = exc_l;
    assign bus.cp0_epc = epc_l;
    assign bus.cp0_bva = bva_l;
    assign bus.cp0_bd  = bd_l;
    assign bus.hw_ip   = hw_ip;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= '0;
            hw_ip <= '0;
        end else begin
            sync0 <= bus.hw_int;
            hw_ip <= sync0;
        end
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_comb begin
        state_n            = state;
        bus.cp0_en         = 1'b0;
        bus.cp0_exl        = 1'b0;
        bus.cp0_exl_clr    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.flush          = accept || state != IDLE;
        bus.stall          = accept || state != IDLE;
        case (state)
            IDLE:     state_n = accept ? COMMIT : IDLE;
            COMMIT: begin
                state_n         = FLUSH;
                bus.cp0_en      = ~eret_l;
                bus.cp0_exl     = ~eret_l;
                bus.cp0_exl_clr = eret_l;
            end
            FLUSH:    state_n = cnt == 4'd1 ? REDIRECT : FLUSH;
            default: begin
                state_n            = IDLE;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = eret_l ? ret_l : EXC_VECTOR;
            end
        endcase
    end

    // Counter is loaded in COMMIT so FLUSH lasts exactly FLUSH_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (state == COMMIT)
            cnt <= 4'(FLUSH_CYCLES);
        else if (state == FLUSH)
            cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_l  <= '0;
            epc_l  <= '0;
            bva_l  <= '0;
            ret_l  <= '0;
            bd_l   <= 1'b0;
            eret_l <= 1'b0;
        end else if (take_int || take_exc) begin
            exc_l  <= take_exc ? bus.m_exc_code : 5'd0;
            if (take_exc)
                bva_l <= bus.m_bva;
            epc_l  <= bus.m_bd ? bus.m_pc - 32'd4 : bus.m_pc;
            bd_l   <= bus.m_bd;
            eret_l <= 1'b0;
        end else if (take_eret) begin
            ret_l  <= bus.epc_in;
            eret_l <= 1'b1;
        end
    end
endmodule

// File: tb/tb_exc_sched.sv
// tb_exc_sched: self-checking bench for exc_sched; directed scenarios followed by random
// events, each checked cycle by cycle against a behavioural model of the event timeline.
module tb_exc_sched;
    localparam int          F   = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  exc_m;
    logic [31:0] epc_m, bva_m;
    logic        bd_m;
    logic [5:0]  hw_m;

    exc_sched_if bus ();
    exc_sched #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(F)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        bus.m_valid     = 1'b0;
        bus.m_exc_valid = 1'b0;
        bus.m_eret      = 1'b0;
        bus.m_bd        = 1'b0;
        bus.m_pc        = '0;
        bus.m_bva       = '0;
        bus.m_exc_code  = '0;
    endtask

    task automatic chk_data(input string tag);
        chk({tag, "_exc"}, 32'(bus.cp0_exc), 32'(exc_m));
        chk({tag, "_epc"}, bus.cp0_epc, epc_m);
        chk({tag, "_bva"}, bus.cp0_bva, bva_m);
        chk({tag, "_bd"}, 32'(bus.cp0_bd), 32'(bd_m));
    endtask

    // Interrupt lines must appear on hw_ip exactly two edges after they change.
    task automatic set_hw(input logic [5:0] v);
        logic [5:0] old;
        old = hw_m;
        bus.hw_int = v;
        nxt;
        @(negedge clk);
        chk("hw_sync_1edge", 32'(bus.hw_ip), 32'(old));
        nxt;
        @(negedge clk);
        chk("hw_sync_2edge", 32'(bus.hw_ip), 32'(v));
        nxt;
        hw_m = v;
    endtask

    // kind: 0 none, 1 interrupt, 2 exception, 3 ERET
    task automatic run_event(input logic iv, input logic ie, input logic ier, input logic [31:0] pc,
                             input logic bd, input logic [4:0] code, input logic [31:0] bva,
                             input logic [31:0] epc);
        int          kind;
        logic        pend;
        logic [31:0] ret;
        bus.m_valid     = iv;
        bus.m_exc_valid = ie;
        bus.m_eret      = ier;
        bus.m_pc        = pc;
        bus.m_bd        = bd;
        bus.m_exc_code  = code;
        bus.m_bva       = bva;
        bus.epc_in      = epc;
        pend = bus.status_ie && !bus.status_exl && ((bus.status_im & {hw_m, bus.cause_ip_sw}) != 8'd0);
        kind = !iv ? 0 : pend ? 1 : ie ? 2 : ier ? 3 : 0;
        ret  = kind == 3 ? epc : VEC;
        @(negedge clk);
        chk("accept_flush", 32'(bus.flush), 32'(kind != 0));
        chk("accept_stall", 32'(bus.stall), 32'(kind != 0));
        chk("accept_cp0_en", 32'(bus.cp0_en), 0);
        nxt;
        if (kind == 1 || kind == 2) begin
            exc_m = kind == 1 ? 5'd0 : code;
            if (kind == 2)
                bva_m = bva;
            epc_m = bd ? pc - 32'd4 : pc;
            bd_m  = bd;
        end
        if (kind != 0) begin
            for (int k = 1; k <= F + 2; k++) begin
                bus.m_valid     = 1'($urandom);
                bus.m_exc_valid = 1'($urandom);
                bus.m_eret      = 1'($urandom);
                bus.m_bd        = 1'($urandom);
                bus.m_pc        = $urandom;
                bus.m_exc_code  = 5'($urandom);
                bus.m_bva       = $urandom;
                bus.epc_in      = $urandom;
                @(negedge clk);
                chk("cp0_en", 32'(bus.cp0_en), 32'(k == 1 && kind != 3));
                chk("cp0_exl_clr", 32'(bus.cp0_exl_clr), 32'(k == 1 && kind == 3));
                if (k == 1 && kind != 3)
                    chk("cp0_exl", 32'(bus.cp0_exl), 1);
                chk("redirect_valid", 32'(bus.redirect_valid), 32'(k == F + 2));
                if (k == F + 2)
                    chk("redirect_pc", bus.redirect_pc, ret);
                chk("busy_flush", 32'(bus.flush), 1);
                chk("busy_stall", 32'(bus.stall), 1);
                chk_data("busy");
                nxt;
            end
        end
        set_idle;
        @(negedge clk);
        chk("idle_flush", 32'(bus.flush), 0);
        chk("idle_cp0_en", 32'(bus.cp0_en), 0);
        chk("idle_redirect", 32'(bus.redirect_valid), 0);
        chk_data("idle");
        nxt;
    endtask

    initial begin
        set_idle;
        bus.hw_int      = '0;
        bus.status_ie   = 1'b0;
        bus.status_exl  = 1'b0;
        bus.status_im   = '0;
        bus.cause_ip_sw = '0;
        bus.epc_in      = '0;
        exc_m = '0;
        epc_m = '0;
        bva_m = '0;
        bd_m  = 1'b0;
        hw_m  = '0;
        repeat (3) nxt;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cp0_en", 32'(bus.cp0_en), 0);
        chk("rst_cp0_exl", 32'(bus.cp0_exl), 0);
        chk("rst_exl_clr", 32'(bus.cp0_exl_clr), 0);
        chk("rst_hw_ip", 32'(bus.hw_ip), 0);
        chk("rst_flush", 32'(bus.flush), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_redirect", 32'(bus.redirect_valid), 0);
        chk("rst_redirect_pc", bus.redirect_pc, 0);
        chk_data("rst");
        nxt;

        run_event(1'b1, 1'b1, 1'b0, 32'h8000_0010, 1'b0, 5'h04, 32'h1, 32'h0);
        run_event(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 5'h04, 32'h1, 32'h0);

        bus.status_ie  = 1'b1;
        bus.status_exl = 1'b0;
        bus.status_im  = 8'h04;
        set_hw(6'h01);
        run_event(1'b1, 1'b1, 1'b0, 32'h8000_0020, 1'b0, 5'h0C, 32'hDEAD_BEEF, 32'h0);

        bus.status_exl = 1'b1;
        run_event(1'b1, 1'b0, 1'b0, 32'h8000_0030, 1'b0, 5'h00, 32'h0, 32'h0);
        run_event(1'b1, 1'b0, 1'b1, 32'h8000_0200, 1'b0, 5'h00, 32'h0, 32'h8000_0100);
        run_event(1'b1, 1'b1, 1'b0, 32'h8000_0040, 1'b1, 5'h0D, 32'h1234, 32'h0);

        for (int i = 0; i < 40; i++) begin
            bus.status_ie   = 1'($urandom);
            bus.status_exl  = ($urandom % 4) == 0;
            bus.status_im   = 8'($urandom);
            bus.cause_ip_sw = 2'($urandom);
            if ($urandom % 4 == 0)
                set_hw(6'($urandom));
            run_event(($urandom % 8) != 0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom),
                      5'($urandom), $urandom, $urandom);
        end

        bus.status_ie   = 1'b0;
        bus.m_valid     = 1'b1;
        bus.m_exc_valid = 1'b1;
        bus.m_exc_code  = 5'h0A;
        bus.m_pc        = 32'h8000_1000;
        bus.m_bva       = 32'h55;
        @(negedge clk);
        chk("rstseq_accept_flush", 32'(bus.flush), 1);
        nxt;
        set_idle;
        @(negedge clk);
        chk("rstseq_commit_en", 32'(bus.cp0_en), 1);
        nxt;
        bus.m_valid     = 1'b1;
        bus.m_exc_valid = 1'b1;
        @(negedge clk);
        chk("rstseq_flush_en", 32'(bus.cp0_en), 0);
        chk("rstseq_in_flush", 32'(bus.flush), 1);
        rst = 1'b1;
        nxt;
        rst = 1'b0;
        set_idle;
        exc_m = '0;
        epc_m = '0;
        bva_m = '0;
        bd_m  = 1'b0;
        @(negedge clk);
        chk("rstseq_hw_ip", 32'(bus.hw_ip), 0);
        chk_data("rstseq");
        for (int k = 0; k <= F + 2; k++) begin
            if (k != 0)
                @(negedge clk);
            chk("rstseq_flush", 32'(bus.flush), 0);
            chk("rstseq_cp0_en", 32'(bus.cp0_en), 0);
            chk("rstseq_redirect", 32'(bus.redirect_valid), 0);
            nxt;
        end
        hw_m = bus.hw_int;

        bus.status_ie   = 1'b1;
        bus.status_exl  = 1'b0;
        bus.status_im   = 8'hFF;
        bus.cause_ip_sw = 2'b00;
        run_event(1'b1, 1'b0, 1'b1, 32'h8000_2000, 1'b0, 5'h00, 32'h0, 32'h8000_3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
